counter_bus_master: RTL and testbench
=====================================

// Module: counter_bus_master
// PURPOSE
//  Bus initiator for the counter peripheral register bus: turns host read/write commands
//  into select/wr/addr/data transactions and returns read data or timeout status.
//  Sits between the host/CPU-side command port and counter-peripheral bus slaves.
//  One outstanding transaction; ack timeout guards against absent or unselected slaves.
// PARAMETERS
//  TIMEOUT   16  cycles in REQ without i_bus_ack before abort (>=2, <=255)
//  RETRIES   1   re-issues after a timeout (only with BUSM_RETRY_EN)
// PORTS
//  i_sysclk      in   1   system clock, all logic on rising edge
//  i_sysrst      in   1   reset, asynchronous assert, ACTIVE-LOW (0 = reset)
//  i_cmd_valid   in   1   command present
//  o_cmd_ready   out  1   master idle, command accepted when valid&ready
//  i_cmd_wr      in   1   1 = register write, 0 = register read
//  i_cmd_addr    in   4   register address (TCCR=1,TCNT=2,OCR=3,ICR=4,TCST=5,TCCR2=6)
//  i_cmd_data    in   16  write data
//  o_rsp_valid   out  1   response present, held until accepted
//  i_rsp_ready   in   1   host accepts response
//  o_rsp_data    out  16  read data (0 for writes and on error)
//  o_rsp_err     out  1   1 = transaction timed out
//  o_bus_select  out  1   peripheral select, held for whole transaction
//  o_bus_wr      out  1   bus write strobe, valid while select high
//  o_reg_addr    out  4   register address, valid while select high
//  o_bus_data    out  16  write data, valid while select high
//  i_bus_data    in   16  read data from slave
//  i_bus_ack     in   1   slave acknowledge
// BEHAVIOUR
//  Reset (i_sysrst=0, async): state IDLE; o_bus_select/o_bus_wr/o_rsp_valid/o_rsp_err=0,
//   o_reg_addr=0, o_bus_data=0, o_rsp_data=0, timeout/retry counters=0. Reset mid-transaction
//   drops select immediately; no response is produced for the aborted command.
//  All outputs registered; o_cmd_ready = (state==IDLE).
//  FSM IDLE -> REQ -> RSP -> IDLE:
//   IDLE: on valid&ready latch wr/addr/data; next cycle select=1, wr/addr/data driven, REQ.
//   REQ: timer counts per cycle. i_bus_ack=1 -> capture i_bus_data (reads) or 0 (writes),
//    err=0, drop select, RSP. Timer reaches TIMEOUT-1 with no ack -> drop select,
//    data=0, err=1, RSP. Ack and terminal count in same cycle: ack wins.
//   RSP: o_rsp_valid=1, data/err stable until i_rsp_ready; then IDLE. Select stays 0.
//  Nominal latency vs 1-cycle-ack slave: accept cycle N, select N+1, ack N+2, rsp_valid N+3.
//  Select always low >=1 cycle between transactions (slave ack is registered and lingers).
//  i_bus_ack ignored outside REQ. Addresses 0,7..15 issued unchanged (slave returns 0).
//  No back-to-back: i_cmd_valid in REQ/RSP waits (ready=0); command fields must hold.
// CONFIGURATION
//  BUSM_RETRY_EN defined: on timeout, if retries_used<RETRIES, drop select one cycle,
//   re-assert with same wr/addr/data, restart timer; err only after final attempt.
//  Not defined: first timeout goes straight to RSP with err=1; retry counter absent.
// STRUCTURE
//  Shared package counter_bus_pkg: ADDR_* register constants, state enum (IDLE,REQ,RSP,
//   plus GAP under BUSM_RETRY_EN), BUS_DW=16, BUS_AW=4.
//  Sub-module bus_ack_timer: load/enable/terminal-count down-counter, width 8.
// TESTING
//  Write TCCR: cmd wr=1 addr=1 data=0x0301, slave acks 1 cycle after select -> select high
//   exactly 2 cycles with wr=1 addr=1 data=0x0301, rsp_valid N+3, err=0, rsp_data=0.
//  Read OCR: slave returns 0xBEEF with ack -> rsp_data=0xBEEF, err=0; ready low in REQ/RSP.
//  No ack, TIMEOUT=16 -> select high 16 cycles then low, rsp err=1 data=0; with
//   BUSM_RETRY_EN RETRIES=1 -> two 16-cycle select windows, 1-cycle gap, then err=1.
//  Ack on terminal-count cycle -> success response, err=0, captured data returned.
//  Backpressure: i_rsp_ready=0 for 5 cycles -> rsp_valid/data held, select stays 0,
//   cmd_ready=0; second command accepted only the cycle after response handshake.
//  Reset pulse while select high -> select=0 same cycle; after release IDLE, no rsp_valid.

Source files
------------

// File: rtl/counter_bus_pkg.sv
// Shared definitions for the counter-peripheral register bus: widths, register map, master states.
// The GAP state exists only when BUSM_RETRY_EN is defined.
package counter_bus_pkg;

   localparam int unsigned BUS_DW = 16;
   localparam int unsigned BUS_AW = 4;

   localparam logic [BUS_AW-1:0] ADDR_TCCR  = 4'd1;
   localparam logic [BUS_AW-1:0] ADDR_TCNT  = 4'd2;
   localparam logic [BUS_AW-1:0] ADDR_OCR   = 4'd3;
   localparam logic [BUS_AW-1:0] ADDR_ICR   = 4'd4;
   localparam logic [BUS_AW-1:0] ADDR_TCST  = 4'd5;
   localparam logic [BUS_AW-1:0] ADDR_TCCR2 = 4'd6;

`ifdef BUSM_RETRY_EN
   typedef enum logic [1:0] {IDLE, REQ, RSP, GAP} busm_state_t;
`else
   typedef enum logic [1:0] {IDLE, REQ, RSP} busm_state_t;
`endif

endpackage

// File: rtl/bus_ack_timer.sv
// Loadable down-counter that flags the last cycle of the bus acknowledge window.
module bus_ack_timer #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_tc
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_tc = i_en && (r_count == '0);

endmodule

// File: rtl/counter_bus_master.sv
// Counter-peripheral bus initiator: host command -> select/wr/addr/data transaction with ack timeout.
// Define BUSM_RETRY_EN to re-issue a timed-out transaction up to RETRIES times before reporting error.
module counter_bus_master
   import counter_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned RETRIES = 1
) (
   input  logic              i_sysclk,
   input  logic              i_sysrst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_wr,
   input  logic [BUS_AW-1:0] i_cmd_addr,
   input  logic [BUS_DW-1:0] i_cmd_data,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [BUS_DW-1:0] o_rsp_data,
   output logic              o_rsp_err,
   output logic              o_bus_select,
   output logic              o_bus_wr,
   output logic [BUS_AW-1:0] o_reg_addr,
   output logic [BUS_DW-1:0] o_bus_data,
   input  logic [BUS_DW-1:0] i_bus_data,
   input  logic              i_bus_ack
);

   localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

   if (TIMEOUT < 2 || TIMEOUT > 255 || RETRIES > 255) begin : g_bad_param
      $error("counter_bus_master: TIMEOUT must be 2..255 and RETRIES <= 255");
   end

   busm_state_t       r_state;
   logic              r_bus_select;
   logic              r_bus_wr;
   logic [BUS_AW-1:0] r_reg_addr;
   logic [BUS_DW-1:0] r_bus_data;
   logic              r_rsp_valid;
   logic [BUS_DW-1:0] r_rsp_data;
   logic              r_rsp_err;
`ifdef BUSM_RETRY_EN
   logic [7:0]        r_retries;
`endif

   logic              w_tmr_load;
   logic              w_tmr_en;
   logic              w_tmr_tc;

`ifdef BUSM_RETRY_EN
   assign w_tmr_load = ((r_state == IDLE) && i_cmd_valid) || (r_state == GAP);
`else
   assign w_tmr_load = (r_state == IDLE) && i_cmd_valid;
`endif
   assign w_tmr_en   = (r_state == REQ);

   bus_ack_timer #(
      .W (8)
   ) u_ack_timer (
      .i_clk      (i_sysclk),
      .i_rst_n    (i_sysrst),
      .i_load     (w_tmr_load),
      .i_load_val (TMO_LOAD),
      .i_en       (w_tmr_en),
      .o_tc       (w_tmr_tc)
   );

   always_ff @(posedge i_sysclk or negedge i_sysrst) begin
      if (!i_sysrst) begin
         r_state      <= IDLE;
         r_bus_select <= 1'b0;
         r_bus_wr     <= 1'b0;
         r_reg_addr   <= '0;
         r_bus_data   <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
`ifdef BUSM_RETRY_EN
         r_retries    <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (i_cmd_valid) begin
                  r_bus_select <= 1'b1;
                  r_bus_wr     <= i_cmd_wr;
                  r_reg_addr   <= i_cmd_addr;
                  r_bus_data   <= i_cmd_data;
                  r_state      <= REQ;
`ifdef BUSM_RETRY_EN
                  r_retries    <= '0;
`endif
               end
            end
            REQ: begin
               // Ack takes priority over the terminal count in the same cycle.
               if (i_bus_ack) begin
                  r_bus_select <= 1'b0;
                  r_rsp_data   <= r_bus_wr ? '0 : i_bus_data;
                  r_rsp_err    <= 1'b0;
                  r_rsp_valid  <= 1'b1;
                  r_state      <= RSP;
               end else if (w_tmr_tc) begin
                  r_bus_select <= 1'b0;
`ifdef BUSM_RETRY_EN
                  if (r_retries < 8'(RETRIES)) begin
                     r_retries <= r_retries + 8'd1;
                     r_state   <= GAP;
                  end else
`endif
                  begin
                     r_rsp_data  <= '0;
                     r_rsp_err   <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_state     <= RSP;
                  end
               end
            end
            RSP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
`ifdef BUSM_RETRY_EN
            GAP: begin
               r_bus_select <= 1'b1;
               r_state      <= REQ;
            end
`endif
            default: begin
               r_bus_select <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

   assign o_cmd_ready  = (r_state == IDLE);
   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_data   = r_rsp_data;
   assign o_rsp_err    = r_rsp_err;
   assign o_bus_select = r_bus_select;
   assign o_bus_wr     = r_bus_wr;
   assign o_reg_addr   = r_reg_addr;
   assign o_bus_data   = r_bus_data;

endmodule

// File: tb/tb_counter_bus_master.sv
// Scoreboard bench for counter_bus_master: randomized commands against a registered-ack slave model.
module tb_counter_bus_master;
   import counter_bus_pkg::*;

   localparam int unsigned T = 16;
   localparam int unsigned R = 1;

   logic        clk;
   logic        rst_n;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic        i_cmd_wr;
   logic [3:0]  i_cmd_addr;
   logic [15:0] i_cmd_data;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [15:0] o_rsp_data;
   logic        o_rsp_err;
   logic        o_bus_select;
   logic        o_bus_wr;
   logic [3:0]  o_reg_addr;
   logic [15:0] o_bus_data;
   logic [15:0] i_bus_data;
   logic        i_bus_ack;

   counter_bus_master #(
      .TIMEOUT (T),
      .RETRIES (R)
   ) dut (
      .i_sysclk     (clk),
      .i_sysrst     (rst_n),
      .i_cmd_valid  (i_cmd_valid),
      .o_cmd_ready  (o_cmd_ready),
      .i_cmd_wr     (i_cmd_wr),
      .i_cmd_addr   (i_cmd_addr),
      .i_cmd_data   (i_cmd_data),
      .o_rsp_valid  (o_rsp_valid),
      .i_rsp_ready  (i_rsp_ready),
      .o_rsp_data   (o_rsp_data),
      .o_rsp_err    (o_rsp_err),
      .o_bus_select (o_bus_select),
      .o_bus_wr     (o_bus_wr),
      .o_reg_addr   (o_reg_addr),
      .o_bus_data   (o_bus_data),
      .i_bus_data   (i_bus_data),
      .i_bus_ack    (i_bus_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          acc;
      logic [15:0] data;
      logic        err;
      int          lat;
   } rsp_t;

   typedef struct {
      int          len;
      int          gap;
      logic        wr;
      logic [3:0]  addr;
      logic [15:0] data;
   } win_t;

   rsp_t rq[$];
   win_t bq[$];

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_hs_cyc = -1;
   int          plan_ack_at = -1;
   logic [15:0] plan_data = '0;
   int          force_stall = 0;
   bit          abort_expected = 1'b0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: what a transaction should look like on the bus and at the response port.
   task automatic expect_txn(input logic wr, input logic [3:0] addr, input logic [15:0] data,
                             input int ack_at, input logic [15:0] rd, input int acc);
      win_t w;
      rsp_t e;
      int   nwin;
      if (abort_expected) return;
      w.wr = wr; w.addr = addr; w.data = data;
      e.acc = acc;
      if (ack_at >= 1 && ack_at <= int'(T) - 1) begin
         w.len = ack_at + 1; w.gap = -1;
         bq.push_back(w);
         e.data = wr ? 16'h0 : rd; e.err = 1'b0; e.lat = ack_at + 2;
      end else begin
`ifdef BUSM_RETRY_EN
         nwin = int'(R) + 1;
`else
         nwin = 1;
`endif
         for (int i = 0; i < nwin; i++) begin
            w.len = int'(T); w.gap = (i == 0) ? -1 : 1;
            bq.push_back(w);
         end
         e.data = 16'h0; e.err = 1'b1; e.lat = nwin * int'(T) + (nwin - 1) + 1;
      end
      rq.push_back(e);
   endtask

   task automatic issue(input logic wr, input logic [3:0] addr, input logic [15:0] data,
                        input int ack_at, input logic [15:0] rd);
      bit got;
      int issue_cyc;
      int exp_acc;
      i_cmd_valid = 1'b1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_data = data;
      issue_cyc = cyc;
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         if (o_cmd_ready) begin
            got = 1'b1;
            plan_ack_at = ack_at;
            plan_data = rd;
            expect_txn(wr, addr, data, ack_at, rd, cyc);
            exp_acc = (issue_cyc > last_hs_cyc + 1) ? issue_cyc : last_hs_cyc + 1;
            chk("accept_cycle", cyc, exp_acc);
         end
         @(posedge clk); #1;
      end
      i_cmd_valid = 1'b0;
      i_cmd_wr = 1'($urandom); i_cmd_addr = 4'($urandom); i_cmd_data = 16'($urandom);
      if (!got) chk("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int n = 0; n < 2000 && (rq.size() != 0 || bq.size() != 0); n++) @(posedge clk);
      #1;
      chk("drain_pending", rq.size() + bq.size(), 0);
   endtask

   // Registered slave: acks plan_ack_at cycles after select rises; random ack noise while unselected.
   int   sk = 0;
   logic sprev = 1'b0;
   always begin
      @(posedge clk); #1;
      if (o_bus_select) begin
         sk = sprev ? sk + 1 : 0;
         if (sk == plan_ack_at) begin
            i_bus_ack = 1'b1; i_bus_data = plan_data;
         end else begin
            i_bus_ack = 1'b0; i_bus_data = 16'($urandom);
         end
      end else begin
         i_bus_ack = ($urandom_range(0, 3) == 0);
         i_bus_data = 16'($urandom);
      end
      sprev = o_bus_select;
   end

   always begin
      @(posedge clk); #1;
      if (force_stall > 0) begin
         i_rsp_ready = 1'b0;
         if (o_rsp_valid) force_stall--;
      end else begin
         i_rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   win_t bw;
   bit   have_w = 1'b0;
   logic bprev = 1'b0;
   int   blen = 0;
   int   blow = 0;
   bit   fbad, rbad;
   always begin
      @(posedge clk); #1;
      if (!rst_n || abort_expected) begin
         bprev = o_bus_select; blen = 0; blow = 0; have_w = 1'b0;
      end else begin
         if (o_bus_select && !bprev) begin
            if (bq.size() == 0) begin
               have_w = 1'b0;
               chk("unexpected_select", 1, 0);
            end else begin
               bw = bq[0]; have_w = 1'b1;
               if (bw.gap >= 0) chk("retry_gap", blow, bw.gap);
               chk("bus_wr", o_bus_wr, bw.wr);
               chk("bus_addr", o_reg_addr, bw.addr);
               chk("bus_data", o_bus_data, bw.data);
            end
            blen = 1; fbad = 1'b0; rbad = 1'b0;
         end else if (o_bus_select) begin
            blen++;
         end
         if (o_bus_select) begin
            if (have_w && (o_bus_wr !== bw.wr || o_reg_addr !== bw.addr || o_bus_data !== bw.data))
               fbad = 1'b1;
            if (o_cmd_ready !== 1'b0) rbad = 1'b1;
         end
         if (!o_bus_select && bprev) begin
            if (have_w) begin
               void'(bq.pop_front());
               chk("select_len", blen, bw.len);
               chk("bus_fields_held", fbad, 0);
               chk("ready_in_req", rbad, 0);
               have_w = 1'b0;
            end
            blow = 1;
         end else if (!o_bus_select) begin
            blow++;
         end
         bprev = o_bus_select;
      end
   end

   rsp_t        re;
   logic        prev_v = 1'b0;
   int          rise = 0;
   logic [15:0] hd;
   logic        he;
   bit          hold_bad, busy_bad;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_v = 1'b0;
      end else begin
         if (o_rsp_valid && !prev_v) begin
            rise = cyc; hd = o_rsp_data; he = o_rsp_err; hold_bad = 1'b0; busy_bad = 1'b0;
         end
         if (o_rsp_valid) begin
            if (o_rsp_data !== hd || o_rsp_err !== he) hold_bad = 1'b1;
            if (o_bus_select !== 1'b0 || o_cmd_ready !== 1'b0) busy_bad = 1'b1;
         end
         if (o_rsp_valid && i_rsp_ready) begin
            if (rq.size() == 0) begin
               chk("unexpected_rsp", 1, 0);
            end else begin
               re = rq.pop_front();
               chk("rsp_data", o_rsp_data, re.data);
               chk("rsp_err", o_rsp_err, re.err);
               chk("rsp_latency", rise - re.acc, re.lat);
               chk("rsp_held", hold_bad, 0);
               chk("rsp_bus_idle", busy_bad, 0);
            end
            last_hs_cyc = cyc;
         end
         prev_v = o_rsp_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit bad;
      logic [3:0] a;
      int ack_at;
      int r;
      rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0; i_cmd_data = '0;
      i_rsp_ready = 1'b0; i_bus_ack = 1'b0; i_bus_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", o_cmd_ready, 1);
      chk("rst_select", o_bus_select, 0);
      chk("rst_bus_wr", o_bus_wr, 0);
      chk("rst_reg_addr", o_reg_addr, 0);
      chk("rst_bus_data", o_bus_data, 0);
      chk("rst_rsp_valid", o_rsp_valid, 0);
      chk("rst_rsp_err", o_rsp_err, 0);
      chk("rst_rsp_data", o_rsp_data, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      issue(1'b1, ADDR_TCCR, 16'h0301, 1, 16'h5A5A);
      issue(1'b0, ADDR_OCR, 16'h0000, 1, 16'hBEEF);
      issue(1'b0, ADDR_TCNT, 16'h1111, -1, 16'h0);
      issue(1'b0, ADDR_ICR, 16'h0000, int'(T) - 1, 16'h1234);
      issue(1'b1, ADDR_TCST, 16'hA5A5, int'(T), 16'h0);
      force_stall = 5;
      issue(1'b0, ADDR_TCST, 16'h0000, 1, 16'hCAFE);
      issue(1'b1, ADDR_TCCR2, 16'h00FF, 3, 16'h0);
      issue(1'b0, 4'd0, 16'h0000, 2, 16'h0000);
      issue(1'b0, 4'd15, 16'h0000, 1, 16'h0000);

      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2) ack_at = -1;
         else if (r < 5) ack_at = 1;
         else ack_at = int'($urandom_range(1, T - 1));
         a = 4'($urandom);
         issue(1'($urandom), a, 16'($urandom), ack_at, 16'($urandom));
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      drain();

      abort_expected = 1'b1;
      issue(1'b0, ADDR_OCR, 16'h0000, -1, 16'h0);
      repeat (3) @(posedge clk);
      #3;
      chk("select_before_reset", o_bus_select, 1);
      rst_n = 1'b0;
      #1;
      chk("reset_drops_select", o_bus_select, 0);
      chk("reset_rsp_valid", o_rsp_valid, 0);
      chk("reset_cmd_ready", o_cmd_ready, 1);
      @(negedge clk) rst_n = 1'b1;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (o_rsp_valid !== 1'b0 || o_bus_select !== 1'b0 || o_cmd_ready !== 1'b1) bad = 1'b1;
      end
      chk("idle_after_reset", bad, 0);
      @(posedge clk); #1;
      abort_expected = 1'b0;
      issue(1'b0, ADDR_TCNT, 16'h0000, 2, 16'h7777);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
